// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with hold, flush and explicit valid; optional bubble counter under ID_EX_BUBBLE_CNT_EN
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              reg_dst_i,
  input  logic              reg_write_i,
  input  logic              alu_src_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              branch_i,
  input  logic              jump_i,
  input  logic [ALUC_W-1:0] alu_ctrl_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              ex_valid,
  output logic              reg_dst_o,
  output logic              reg_write_o,
  output logic              alu_src_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              branch_o,
  output logic              jump_o,
  output logic [ALUC_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic [REG_AW-1:0] rd_o
);

  // Pipeline entry: reset and flush both clear to a bubble; hold freezes; otherwise load.
  // Controls are gated by id_valid so a bubble never carries a side-effecting control.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ex_valid     <= 1'b0;
      reg_dst_o    <= 1'b0;
      reg_write_o  <= 1'b0;
      alu_src_o    <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      branch_o     <= 1'b0;
      jump_o       <= 1'b0;
      alu_ctrl_o   <= '0;
      pc_plus4_o   <= '0;
      rs_data_o    <= '0;
      rt_data_o    <= '0;
      imm_o        <= '0;
      rs_o         <= '0;
      rt_o         <= '0;
      rd_o         <= '0;
    end else if (!hold) begin
      ex_valid     <= id_valid;
      reg_dst_o    <= id_valid & reg_dst_i;
      reg_write_o  <= id_valid & reg_write_i;
      alu_src_o    <= id_valid & alu_src_i;
      mem_read_o   <= id_valid & mem_read_i;
      mem_write_o  <= id_valid & mem_write_i;
      mem_to_reg_o <= id_valid & mem_to_reg_i;
      branch_o     <= id_valid & branch_i;
      jump_o       <= id_valid & jump_i;
      alu_ctrl_o   <= id_valid ? alu_ctrl_i : '0;
      pc_plus4_o   <= pc_plus4_i;
      rs_data_o    <= rs_data_i;
      rt_data_o    <= rt_data_i;
      imm_o        <= imm_i;
      rs_o         <= rs_i;
      rt_o         <= rt_i;
      rd_o         <= rd_i;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Count every edge that loads a bubble (flush, or an unstalled load of a nop); wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= 32'd0;
    end else if (flush || (!hold && !id_valid)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg with directed vectors
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        v;
    logic [7:0]  ctl;   // {reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump}
    logic [3:0]  aluc;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  s;
    logic [4:0]  t;
    logic [4:0]  d;
    logic [31:0] bc;
  } out_t;

  logic clk = 1'b0;
  logic rst_n, hold, flush, id_valid;
  logic [7:0] ctl_i;
  logic [3:0] alu_ctrl_i;
  logic [31:0] pc_plus4_i, rs_data_i, rt_data_i, imm_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic ex_valid, reg_dst_o, reg_write_o, alu_src_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o, jump_o;
  logic [3:0] alu_ctrl_o;
  logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0] rs_o, rt_o, rd_o;
  logic [31:0] bc_act;

  int total = 0;
  int bad = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .reg_dst_i(ctl_i[7]), .reg_write_i(ctl_i[6]), .alu_src_i(ctl_i[5]), .mem_read_i(ctl_i[4]),
    .mem_write_i(ctl_i[3]), .mem_to_reg_i(ctl_i[2]), .branch_i(ctl_i[1]), .jump_i(ctl_i[0]),
    .alu_ctrl_i(alu_ctrl_i), .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .ex_valid(ex_valid), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o), .alu_src_o(alu_src_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .branch_o(branch_o), .jump_o(jump_o), .alu_ctrl_o(alu_ctrl_o), .pc_plus4_o(pc_plus4_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt(bc_act),
`endif
    .rd_o(rd_o)
  );

`ifndef ID_EX_BUBBLE_CNT_EN
  assign bc_act = 32'd0;
`endif

  function automatic out_t mk(input logic v, input logic [7:0] c, input logic [3:0] a,
                              input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] imm, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [31:0] bc);
    out_t o;
    o.v = v; o.ctl = c; o.aluc = a; o.pc = pc; o.rs = rs; o.rt = rt; o.imm = imm;
    o.s = s; o.t = t; o.d = d;
`ifdef ID_EX_BUBBLE_CNT_EN
    o.bc = bc;
`else
    o.bc = 32'd0;
`endif
    return o;
  endfunction

  // Drive one vector, let one edge pass, queue the hand-computed expectation.
  task automatic apply(input logic r, input logic h, input logic f, input logic iv,
                       input logic [7:0] c, input logic [3:0] a, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input out_t e);
    rst_n = r; hold = h; flush = f; id_valid = iv; ctl_i = c; alu_ctrl_i = a;
    pc_plus4_i = pc; rs_data_i = rs; rt_data_i = rt; imm_i = imm; rs_i = s; rt_i = t; rd_i = d;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: every settled output cycle with a pending expectation is compared.
  always @(negedge clk) begin
    out_t act;
    out_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act.v = ex_valid;
      act.ctl = {reg_dst_o, reg_write_o, alu_src_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o, jump_o};
      act.aluc = alu_ctrl_o; act.pc = pc_plus4_o; act.rs = rs_data_o; act.rt = rt_data_o;
      act.imm = imm_o; act.s = rs_o; act.t = rt_o; act.d = rd_o; act.bc = bc_act;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle_check#%0d actual=%h required=%h", total, act, e);
      end
    end
  end

  out_t z;
  out_t v2;

  initial begin
    z  = mk(0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    v2 = mk(1, 8'hA0, 4'h5, 32'h104, 32'h1, 32'h2, 32'h3, 5'd3, 5'd4, 5'd5, 0);
    // reset with every input nonzero, two edges
    repeat (2) apply(0, 1, 1, 1, 8'hFF, 4'hF, 32'hFFFF_FFFF, 32'h1234, 32'h5678, 32'h9ABC, 5'd31, 5'd31, 5'd31, z);
    // basic load
    apply(1, 0, 0, 1, 8'h40, 4'h2, 32'h100, 32'hAA, 32'h55, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd9,
          mk(1, 8'h40, 4'h2, 32'h100, 32'hAA, 32'h55, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd9, 0));
    // load the entry to be held
    apply(1, 0, 0, 1, 8'hA0, 4'h5, 32'h104, 32'h1, 32'h2, 32'h3, 5'd3, 5'd4, 5'd5, v2);
    // hold for three edges with different inputs (and id_valid=0: no count)
    repeat (3) apply(1, 1, 0, 0, 8'hFF, 4'hE, 32'h200, 32'hDEAD, 32'hBEEF, 32'hF00D, 5'd7, 5'd7, 5'd7, v2);
    // hold released
    apply(1, 0, 0, 1, 8'h08, 4'h7, 32'h200, 32'h11, 32'h22, 32'h33, 5'd6, 5'd7, 5'd8,
          mk(1, 8'h08, 4'h7, 32'h200, 32'h11, 32'h22, 32'h33, 5'd6, 5'd7, 5'd8, 0));
    // flush together with hold and mem_write
    apply(1, 1, 1, 1, 8'h08, 4'h3, 32'h204, 32'h99, 32'h88, 32'h77, 5'd1, 5'd2, 5'd3,
          mk(0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'd1));
    // bubble with stray reg_write/mem_read: controls cleared, data loads
    apply(1, 0, 0, 0, 8'h50, 4'hF, 32'h300, 32'h44, 32'h55, 32'h66, 5'd10, 5'd11, 5'd12,
          mk(0, 8'h00, 4'h0, 32'h300, 32'h44, 32'h55, 32'h66, 5'd10, 5'd11, 5'd12, 32'd2));
    // plain flush
    apply(1, 0, 1, 1, 8'hFF, 4'h9, 32'h400, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1,
          mk(0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'd3));
    // all-ones load
    apply(1, 0, 0, 1, 8'hFF, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 5'd0, 5'd16,
          mk(1, 8'hFF, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 5'd0, 5'd16, 32'd3));
    // hold edge keeps it
    apply(1, 1, 0, 0, 8'h00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
          mk(1, 8'hFF, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 5'd0, 5'd16, 32'd3));
    // reset asserted mid-stall
    apply(0, 1, 0, 1, 8'hFF, 4'hF, 32'h500, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, z);
    // load after reset
    apply(1, 0, 0, 1, 8'h21, 4'h1, 32'h504, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3,
          mk(1, 8'h21, 4'h1, 32'h504, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 0));
`ifdef ID_EX_BUBBLE_CNT_EN
    // counter wrap: preload all-ones, load one bubble, then a hold edge
    @(negedge clk);
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt;
    apply(1, 0, 0, 0, 8'h00, 4'h0, 32'h600, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
          mk(0, 8'h00, 4'h0, 32'h600, 0, 0, 0, 0, 0, 0, 32'd0));
    apply(1, 1, 0, 0, 8'h00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
          mk(0, 8'h00, 4'h0, 32'h600, 0, 0, 0, 0, 0, 0, 32'd0));
`endif
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
